// File: rtl/calc_pkg.sv
// Shared definitions for the calculator display link: frame geometry,
// receiver state encoding and 7-segment glyphs (active-high, seg[0]=a).
package calc_pkg;

    localparam int BCD_DIGITS = 4;
    localparam int FRAME_BITS = 16;

    // Bit counter saturates one past a full frame to flag an over-long frame.
    localparam int          CNT_W   = 5;
    localparam logic [4:0]  CNT_FULL = 5'd16;
    localparam logic [4:0]  CNT_OVF  = 5'd17;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } rx_state_e;

    // Glyph bit order is {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // True when every nibble of the frame is a legal BCD digit.
    function automatic logic bcd_ok(input logic [FRAME_BITS-1:0] frame);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (frame[i*4 +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder. Output is active-high; the
// caller applies panel polarity. Non-BCD codes and the blank flag give
// an unlit digit.
module bcd_to_7seg
    import calc_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    // Glyph lookup with blanking override.
    always_comb begin
        // NOTE: assign a default before the case so every path drives seg_o
        // and no latch is inferred.
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (bcd_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/display_rx.sv
// Display-side receiver for the 3-wire serial link. Synchronizes the
// sender's pins into clk, deserializes 16-bit BCD frames, keeps the last
// good frame and scans it onto a 4-digit multiplexed 7-segment display.
module display_rx
    import calc_pkg::*;
#(
    parameter int SCAN_DIV    = 32,
    parameter int BLANK_LZ    = 1,
    parameter int SEG_ACT_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ser_data,
    input  logic                  ser_clk,
    input  logic                  ser_latch,
    output logic [FRAME_BITS-1:0] bcd_out,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic [6:0]            seg,
    output logic [BCD_DIGITS-1:0] an
);

    localparam int              SCAN_W   = $clog2(SCAN_DIV);
    localparam logic [6:0]      SEG_POL  = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [3:0]      AN_POL   = (SEG_ACT_LOW != 0) ? 4'hF  : 4'h0;

    // Two synchronizer stages plus, for clock and latch, an edge stage.
    logic [2:0] sclk_q;
    logic [2:0] slat_q;
    logic [1:0] sdat_q;

    logic clk_rise;
    logic lat_rise;
    logic data_s;

    // Receiver state and datapath.
    rx_state_e             state_q, state_d;
    logic [FRAME_BITS-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [FRAME_BITS-1:0] bcd_q, bcd_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;

    // Scan.
    logic [SCAN_W-1:0]     scan_q;
    logic [1:0]            dig_q;
    logic [1:0]            nxt_dig;
    logic                  scan_wrap;
    logic [3:0]            blank_vec;
    logic [6:0]            glyph;
    logic [6:0]            seg_q;
    logic [3:0]            an_q;

    assign clk_rise = sclk_q[1] & ~sclk_q[2];
    assign lat_rise = slat_q[1] & ~slat_q[2];
    assign data_s   = sdat_q[1];

    // Pin synchronizers and edge registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, whatever the statement order.
        if (!rst) begin
            sclk_q <= '0;
            slat_q <= '0;
            sdat_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], ser_clk};
            slat_q <= {slat_q[1:0], ser_latch};
            sdat_q <= {sdat_q[0], ser_data};
        end
    end

    // FSM state register together with the datapath it controls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Next state: a frame opens on its first bit and closes on any latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (clk_rise && !lat_rise) state_d = ST_SHIFT;
            ST_SHIFT: if (lat_rise)              state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath outputs: shift first, then judge the frame on the shifted view
    // so a bit and the latch arriving together still make a complete frame.
    always_comb begin
        logic [FRAME_BITS-1:0] sh_sreg;
        logic [CNT_W-1:0]      cnt_base;
        logic [CNT_W-1:0]      sh_cnt;

        cnt_base = (state_q == ST_IDLE) ? '0 : cnt_q;
        sh_sreg  = sreg_q;
        sh_cnt   = cnt_base;
        if (clk_rise) begin
            sh_sreg = {sreg_q[FRAME_BITS-2:0], data_s};
            sh_cnt  = (cnt_base == CNT_OVF) ? cnt_base : cnt_base + 5'd1;
        end

        sreg_d  = sh_sreg;
        cnt_d   = sh_cnt;
        bcd_d   = bcd_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (lat_rise) begin
            cnt_d = '0;
            if (sh_cnt == CNT_FULL && bcd_ok(sh_sreg)) begin
                bcd_d   = sh_sreg;
                valid_d = 1'b1;
            end else begin
                err_d   = 1'b1;
            end
        end
    end

    assign bcd_out     = bcd_q;
    assign frame_valid = valid_q;
    assign frame_err   = err_q;

    assign scan_wrap = (scan_q == SCAN_W'(SCAN_DIV - 1));
    assign nxt_dig   = dig_q + 2'd1;

    // Leading-zero mask: digit k blanks when it and every higher digit are 0.
    always_comb begin
        logic zero_above;
        blank_vec  = '0;
        zero_above = 1'b1;
        for (int k = BCD_DIGITS - 1; k >= 1; k--) begin
            zero_above   = zero_above && (bcd_q[k*4 +: 4] == 4'd0);
            blank_vec[k] = (BLANK_LZ != 0) && zero_above;
        end
    end

    bcd_to_7seg u_dec (
        .bcd_i   (bcd_q[{nxt_dig, 2'b00} +: 4]),
        .blank_i (blank_vec[nxt_dig]),
        .seg_o   (glyph)
    );

    // Refresh scan: seg and an reload together at each slot boundary.
    always_ff @(posedge clk) begin
        if (!rst) begin
            scan_q <= '0;
            dig_q  <= '0;
            seg_q  <= SEG_POL;
            an_q   <= AN_POL;
        end else if (scan_wrap) begin
            scan_q <= '0;
            dig_q  <= nxt_dig;
            seg_q  <= glyph ^ SEG_POL;
            an_q   <= (4'b0001 << nxt_dig) ^ AN_POL;
        end else begin
            scan_q <= scan_q + 1'b1;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: tb/tb_display_rx.sv
// Directed bench for display_rx: frame accept/reject, leading-zero
// blanking, scan content, reset mid-frame and coincident bit/latch edges.
module tb_display_rx;

    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ser_data = 1'b0;
    logic        ser_clk = 1'b0;
    logic        ser_latch = 1'b0;
    logic [15:0] bcd_out;
    logic        frame_valid;
    logic        frame_err;
    logic [6:0]  seg;
    logic [3:0]  an;

    int n_cmp = 0;
    int n_err = 0;
    int nv, ne;

    display_rx #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1), .SEG_ACT_LOW(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .ser_data    (ser_data),
        .ser_clk     (ser_clk),
        .ser_latch   (ser_latch),
        .bcd_out     (bcd_out),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .seg         (seg),
        .an          (an)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        ser_data = b;
        repeat (2) @(negedge clk);
        ser_clk = 1'b1;
        repeat (3) @(negedge clk);
        ser_clk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) send_bit(w[i]);
    endtask

    // Raise the latch and count validity/error pulses over a bounded window.
    task automatic do_latch(output int v, output int e);
        v = 0;
        e = 0;
        @(negedge clk);
        ser_latch = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            v += int'(frame_valid);
            e += int'(frame_err);
            if (i == 3) ser_latch = 1'b0;
        end
    endtask

    // Wait (bounded) for digit k's slot, then compare the active-low glyph.
    task automatic check_digit(input int k, input logic [6:0] glyph_hi);
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        exp_an  = ~(4'b0001 << k);
        exp_seg = ~glyph_hi;
        for (int i = 0; i < 10 * SCAN_DIV && an !== exp_an; i++) @(negedge clk);
        check($sformatf("an_dig%0d", k), 32'(an), 32'(exp_an));
        check($sformatf("seg_dig%0d", k), 32'(seg), 32'(exp_seg));
    endtask

    task automatic settle_scan();
        repeat (5 * SCAN_DIV + 4) @(negedge clk);
    endtask

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_bcd",   32'(bcd_out),     32'h0000);
        check("rst_valid", 32'(frame_valid), 32'h0);
        check("rst_err",   32'(frame_err),   32'h0);
        check("rst_seg",   32'(seg),         32'h7F);
        check("rst_an",    32'(an),          32'hF);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 1: good frame 1234, scan shows 4,3,2,1 on an[0..3].
        send_word(16'h1234);
        do_latch(nv, ne);
        check("t1_valid_cnt", 32'(nv), 32'd1);
        check("t1_err_cnt",   32'(ne), 32'd0);
        check("t1_bcd",       32'(bcd_out), 32'h1234);
        settle_scan();
        check_digit(0, 7'h66);
        check_digit(1, 7'h4F);
        check_digit(2, 7'h5B);
        check_digit(3, 7'h06);

        // 2: short frame rejected, then 0042 accepted.
        for (int i = 0; i < 15; i++) send_bit(i[0]);
        do_latch(nv, ne);
        check("t2_short_err",   32'(ne), 32'd1);
        check("t2_short_valid", 32'(nv), 32'd0);
        check("t2_short_hold",  32'(bcd_out), 32'h1234);
        send_word(16'h0042);
        do_latch(nv, ne);
        check("t2_valid_cnt", 32'(nv), 32'd1);
        check("t2_bcd",       32'(bcd_out), 32'h0042);
        settle_scan();
        check_digit(0, 7'h5B);
        check_digit(1, 7'h66);
        check_digit(2, 7'h00);

        // 3: over-long frame and empty frame both rejected.
        for (int i = 0; i < 18; i++) send_bit(i[1]);
        do_latch(nv, ne);
        check("t3_long_err",   32'(ne), 32'd1);
        check("t3_long_valid", 32'(nv), 32'd0);
        check("t3_long_hold",  32'(bcd_out), 32'h0042);
        do_latch(nv, ne);
        check("t3_empty_err",  32'(ne), 32'd1);
        check("t3_empty_hold", 32'(bcd_out), 32'h0042);

        // 4: non-BCD nibble rejected.
        send_word(16'h12A4);
        do_latch(nv, ne);
        check("t4_err",   32'(ne), 32'd1);
        check("t4_valid", 32'(nv), 32'd0);
        check("t4_hold",  32'(bcd_out), 32'h0042);

        // 5: leading-zero blanking (also proves the count restarted at 0).
        send_word(16'h0007);
        do_latch(nv, ne);
        check("t5_valid_cnt", 32'(nv), 32'd1);
        check("t5_bcd",       32'(bcd_out), 32'h0007);
        settle_scan();
        check_digit(0, 7'h07);
        check_digit(1, 7'h00);
        check_digit(2, 7'h00);
        check_digit(3, 7'h00);
        send_word(16'h0000);
        do_latch(nv, ne);
        check("t5_zero_valid", 32'(nv), 32'd1);
        check("t5_zero_bcd",   32'(bcd_out), 32'h0000);
        settle_scan();
        check_digit(0, 7'h3F);
        check_digit(1, 7'h00);
        check_digit(3, 7'h00);

        // 6: reset mid-frame, then a clean 9876 frame.
        send_word(16'h3456);
        do_latch(nv, ne);
        check("t6_pre_bcd", 32'(bcd_out), 32'h3456);
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_rst_bcd",   32'(bcd_out),     32'h0000);
        check("t6_rst_valid", 32'(frame_valid), 32'h0);
        check("t6_rst_err",   32'(frame_err),   32'h0);
        check("t6_rst_seg",   32'(seg),         32'h7F);
        check("t6_rst_an",    32'(an),          32'hF);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        send_word(16'h9876);
        do_latch(nv, ne);
        check("t6_valid_cnt", 32'(nv), 32'd1);
        check("t6_err_cnt",   32'(ne), 32'd0);
        check("t6_bcd",       32'(bcd_out), 32'h9876);
        settle_scan();
        check_digit(3, 7'h6F);
        check_digit(0, 7'h7D);

        // 7: 16th bit clock rise and latch rise in the same cycle.
        for (int i = 15; i >= 1; i--) send_bit(logic'((16'h0315 >> i) & 16'h1));
        @(negedge clk);
        ser_data = 1'b1;
        repeat (2) @(negedge clk);
        ser_clk   = 1'b1;
        ser_latch = 1'b1;
        nv = 0;
        ne = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            nv += int'(frame_valid);
            ne += int'(frame_err);
            if (i == 3) begin
                ser_clk   = 1'b0;
                ser_latch = 1'b0;
            end
        end
        check("t7_valid_cnt", 32'(nv), 32'd1);
        check("t7_err_cnt",   32'(ne), 32'd0);
        check("t7_bcd",       32'(bcd_out), 32'h0315);
        settle_scan();
        check_digit(2, 7'h4F);
        check_digit(3, 7'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
